// File: rtl/stack_machine_p.sv
// Stack-machine processor: 4-bit opcode + DW-bit operand, memory-mapped in/out/error words.
// Optional multiplier (opcode 9) is built only when STACK_MACHINE_MUL_EN is defined.
module stack_machine_p #(
  parameter int DW     = 8,
  parameter int SDEPTH = 8,
  parameter int PAW    = 5,
  parameter int DAW    = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [DW-1:0]   in,
  input  logic            start,
  input  logic            prog_we,
  input  logic [PAW-1:0]  prog_addr,
  input  logic [DW+3:0]   prog_wdata,
  output logic [DW-1:0]   out,
  output logic            error,
  output logic            busy,
  output logic            halted,
  output logic [1:0]      fault_code
);

  localparam int SIW = $clog2(SDEPTH);
  localparam int SPW = SIW + 1;
  localparam logic [SPW-1:0] SP_FULL  = SPW'(SDEPTH);
  localparam logic [DAW-1:0] ADDR_OUT = '1;
  localparam logic [DAW-1:0] ADDR_IN  = ADDR_OUT - DAW'(1);
  localparam logic [DAW-1:0] ADDR_ERR = ADDR_OUT - DAW'(2);

  localparam logic [3:0] OP_PUSHC = 4'd0;
  localparam logic [3:0] OP_PUSHM = 4'd1;
  localparam logic [3:0] OP_POP   = 4'd2;
  localparam logic [3:0] OP_J     = 4'd3;
  localparam logic [3:0] OP_JZ    = 4'd4;
  localparam logic [3:0] OP_JS    = 4'd5;
  localparam logic [3:0] OP_ADD   = 4'd6;
  localparam logic [3:0] OP_SUB   = 4'd7;
  localparam logic [3:0] OP_HALT  = 4'd8;
  localparam logic [3:0] OP_MUL   = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, HALT, FAULT} state_t;

  state_t state, state_n;

  logic [PAW-1:0] pc, pc_n;
  logic [SPW-1:0] sp, sp_n, sp_m1;
  logic           flag_z, flag_s, z_n, s_n;
  logic [1:0]     fc_n, flt;
  logic [DW-1:0]  in_reg;

  logic [DW-1:0]   stack [SDEPTH];
  logic [DW+3:0]   pmem  [2**PAW];
  logic [DW-1:0]   dmem  [2**DAW];

  logic [DW+3:0]  instr;
  logic [3:0]     opcode;
  logic [DW-1:0]  operand;
  logic [DAW-1:0] daddr;
  logic [SIW-1:0] top_idx, nxt_idx, stk_idx;
  logic [DW-1:0]  top_val, nxt_val, mem_rdata, alu_res, stk_wdata;
  logic           stk_we, mem_we, is_arith;

  assign instr   = pmem[pc];
  assign opcode  = instr[DW+3:DW];
  assign operand = instr[DW-1:0];
  assign daddr   = operand[DAW-1:0];
  assign sp_m1   = sp - SPW'(1);
  assign top_idx = sp_m1[SIW-1:0];
  assign nxt_idx = top_idx - SIW'(1);
  assign top_val = stack[top_idx];
  assign nxt_val = stack[nxt_idx];
  assign busy    = (state == RUN);
  assign halted  = (state == HALT);

  always_comb begin
    if (daddr == ADDR_OUT)      mem_rdata = out;
    else if (daddr == ADDR_IN)  mem_rdata = in_reg;
    else if (daddr == ADDR_ERR) mem_rdata = {{(DW-1){1'b0}}, error};
    else                        mem_rdata = dmem[daddr];
  end

  always_comb begin
    is_arith = (opcode == OP_ADD) || (opcode == OP_SUB);
    case (opcode)
      OP_SUB:  alu_res = nxt_val - top_val;
`ifdef STACK_MACHINE_MUL_EN
      OP_MUL: begin
        alu_res  = nxt_val * top_val;
        is_arith = 1'b1;
      end
`endif
      default: alu_res = nxt_val + top_val;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    sp_n      = sp;
    z_n       = flag_z;
    s_n       = flag_s;
    fc_n      = fault_code;
    stk_we    = 1'b0;
    stk_idx   = top_idx;
    stk_wdata = alu_res;
    mem_we    = 1'b0;
    flt       = 2'd0;
    case (state)
      RUN: begin
        pc_n = pc + PAW'(1);
        case (opcode)
          OP_PUSHC, OP_PUSHM: begin
            if (sp == SP_FULL) flt = 2'd1;
            else begin
              stk_we    = 1'b1;
              stk_idx   = sp[SIW-1:0];
              stk_wdata = (opcode == OP_PUSHC) ? operand : mem_rdata;
              sp_n      = sp + SPW'(1);
            end
          end
          OP_POP: begin
            if (sp == '0) flt = 2'd2;
            else begin
              mem_we = 1'b1;
              sp_n   = sp_m1;
            end
          end
          OP_J, OP_JZ, OP_JS: begin
            if (sp == '0) flt = 2'd2;
            else begin
              sp_n = sp_m1;
              if ((opcode == OP_J) || (opcode == OP_JZ && flag_z) || (opcode == OP_JS && flag_s))
                pc_n = top_val[PAW-1:0];
            end
          end
          OP_HALT: begin
            state_n = HALT;
            pc_n    = pc;
          end
          default: begin
            if (!is_arith) flt = 2'd3;
            else if (sp < SPW'(2)) flt = 2'd2;
            else begin
              stk_we  = 1'b1;
              stk_idx = nxt_idx;
              sp_n    = sp_m1;
              z_n     = (alu_res == '0);
              s_n     = alu_res[DW-1];
            end
          end
        endcase
        // a faulting instruction must leave no architectural trace
        if (flt != 2'd0) begin
          state_n = FAULT;
          fc_n    = flt;
          pc_n    = pc;
          sp_n    = sp;
          z_n     = flag_z;
          s_n     = flag_s;
          stk_we  = 1'b0;
          mem_we  = 1'b0;
        end
      end
      default: begin
        if (start) begin
          state_n = RUN;
          pc_n    = '0;
          sp_n    = '0;
          z_n     = 1'b0;
          s_n     = 1'b0;
          fc_n    = 2'd0;
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      sp         <= '0;
      flag_z     <= 1'b0;
      flag_s     <= 1'b0;
      fault_code <= 2'd0;
      out        <= '0;
      error      <= 1'b0;
      in_reg     <= '0;
    end else begin
      pc         <= pc_n;
      sp         <= sp_n;
      flag_z     <= z_n;
      flag_s     <= s_n;
      fault_code <= fc_n;
      in_reg     <= in;
      error      <= out[DW-1] | in[DW-1];
      if (mem_we && daddr == ADDR_OUT) out <= top_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < SDEPTH; i++) stack[i] <= '0;
    end else if (stk_we) begin
      stack[stk_idx] <= stk_wdata;
    end
  end

  // program and unmapped data memory deliberately survive reset
  always_ff @(posedge clk) begin
    if (prog_we && state != RUN) pmem[prog_addr] <= prog_wdata;
    if (mem_we && daddr < ADDR_ERR) dmem[daddr] <= top_val;
  end

endmodule

// File: tb/tb_stack_machine_p.sv
// Directed self-checking bench for stack_machine_p; expectations follow STACK_MACHINE_MUL_EN.
module tb_stack_machine_p;
  localparam int DW  = 8;
  localparam int PAW = 5;

  localparam logic [3:0] PUSHC = 4'd0, PUSHM = 4'd1, POP = 4'd2, JS = 4'd5, JZ = 4'd4;
  localparam logic [3:0] ADD = 4'd6, SUB = 4'd7, HLT = 4'd8, MUL = 4'd9, BAD = 4'd15;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            start = 1'b0;
  logic            prog_we = 1'b0;
  logic [DW-1:0]   in_d = '0;
  logic [PAW-1:0]  prog_addr = '0;
  logic [DW+3:0]   prog_wdata = '0;
  logic [DW-1:0]   out;
  logic            error, busy, halted;
  logic [1:0]      fault_code;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  stack_machine_p dut (
    .clk(clk), .rst(rst), .in(in_d), .start(start),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_wdata(prog_wdata),
    .out(out), .error(error), .busy(busy), .halted(halted), .fault_code(fault_code)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic prog(input int a, input logic [3:0] op, input logic [7:0] opd);
    @(negedge clk);
    prog_we    = 1'b1;
    prog_addr  = a[PAW-1:0];
    prog_wdata = {op, opd};
    @(negedge clk);
    prog_we    = 1'b0;
  endtask

  task automatic run_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic wait_done(input int max);
    int n = 0;
    while (busy === 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
    chk("run_terminates", {31'd0, busy === 1'b0}, 32'd1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_halted", halted, 0);
    chk("rst_out", out, 0);
    chk("rst_error", error, 0);
    chk("rst_fault", fault_code, 0);
    chk("rst_sp", dut.sp, 0);
    rst = 1'b0;

    // 5+3, pop to out, halt: HALT reached on the 5th RUN cycle
    prog(0, PUSHC, 8'd5); prog(1, PUSHC, 8'd3); prog(2, ADD, 8'd0);
    prog(3, POP, 8'hFF);  prog(4, HLT, 8'd0);
    run_start();
    repeat (4) @(posedge clk);
    #1;
    chk("a_busy_c4", busy, 1);
    chk("a_out_c4", out, 8);
    @(posedge clk);
    #1;
    chk("a_halted_c5", halted, 1);
    chk("a_out", out, 8);
    chk("a_z", dut.flag_z, 0);
    chk("a_sp", dut.sp, 0);

    // 3-5 = 0xFE sets s; JS taken to 7
    prog(0, PUSHC, 8'd3); prog(1, PUSHC, 8'd5); prog(2, SUB, 8'd0);
    prog(3, PUSHC, 8'd7); prog(4, JS, 8'd0);    prog(7, HLT, 8'd0);
    run_start();
    wait_done(50);
    chk("b_halted", halted, 1);
    chk("b_pc", dut.pc, 7);
    chk("b_sp", dut.sp, 1);
    chk("b_stack0", dut.stack[0], 8'hFE);
    chk("b_s", dut.flag_s, 1);
    chk("b_z", dut.flag_z, 0);

    // 1-1 = 0: JS not taken, JZ taken to 9
    prog(0, PUSHC, 8'd1); prog(1, PUSHC, 8'd1); prog(2, SUB, 8'd0);
    prog(3, PUSHC, 8'd20); prog(4, JS, 8'd0);   prog(5, PUSHC, 8'd9);
    prog(6, JZ, 8'd0);    prog(9, HLT, 8'd0);
    run_start();
    wait_done(50);
    chk("c_halted", halted, 1);
    chk("c_pc", dut.pc, 9);
    chk("c_sp", dut.sp, 1);
    chk("c_z", dut.flag_z, 1);
    chk("c_stack0", dut.stack[0], 0);

    // overflow on the 9th push
    for (int i = 0; i < 9; i++) prog(i, PUSHC, 8'(10 + i));
    run_start();
    wait_done(50);
    chk("d_fault", fault_code, 1);
    chk("d_sp", dut.sp, 8);
    chk("d_top", dut.stack[7], 8'h11);
    chk("d_pc", dut.pc, 8);
    chk("d_halted", halted, 0);

    // underflow, then restart from FAULT
    prog(0, PUSHC, 8'd1); prog(1, ADD, 8'd0);
    run_start();
    wait_done(50);
    chk("e_fault", fault_code, 2);
    chk("e_sp", dut.sp, 1);
    chk("e_stack0", dut.stack[0], 1);
    chk("e_pc", dut.pc, 1);
    run_start();
    chk("e_restart_busy", busy, 1);
    chk("e_restart_fault", fault_code, 0);
    wait_done(50);
    chk("e_refault", fault_code, 2);

    // opcode 9 depends on build; opcode 15 always illegal
    prog(0, PUSHC, 8'd6); prog(1, PUSHC, 8'd7); prog(2, MUL, 8'd0);
    prog(3, POP, 8'hFF);  prog(4, HLT, 8'd0);
    run_start();
    wait_done(50);
`ifdef STACK_MACHINE_MUL_EN
    chk("f_mul_halted", halted, 1);
    chk("f_mul_out", out, 42);
    chk("f_mul_fault", fault_code, 0);
`else
    chk("f_mul_fault", fault_code, 3);
    chk("f_mul_pc", dut.pc, 2);
    chk("f_mul_sp", dut.sp, 2);
    chk("f_mul_out_kept", out, 8);
`endif
    prog(0, PUSHC, 8'd6); prog(1, BAD, 8'd0);
    run_start();
    wait_done(50);
    chk("f_op15_fault", fault_code, 3);
    chk("f_op15_pc", dut.pc, 1);
    chk("f_op15_sp", dut.sp, 1);

    // in-port capture, error bit, scratch word at 0x10
    in_d = 8'h81;
    prog(0, PUSHC, 8'h5A); prog(1, POP, 8'h10); prog(2, PUSHM, 8'hFE);
    prog(3, POP, 8'hFF);   prog(4, HLT, 8'd0);
    run_start();
    wait_done(50);
    chk("g_out_in", out, 8'h81);
    chk("g_error_in", error, 1);
    in_d = 8'h00;
    repeat (2) @(negedge clk);
    chk("g_error_out", error, 1);

    // reset mid-RUN, then rerun unchanged program
    prog(0, PUSHC, 8'd5); prog(1, PUSHC, 8'd3); prog(2, ADD, 8'd0);
    prog(3, POP, 8'hFF);  prog(4, HLT, 8'd0);
    run_start();
    repeat (4) @(posedge clk);
    #1;
    chk("h_out_prerst", out, 8);
    rst = 1'b1;
    #1;
    chk("h_rst_busy", busy, 0);
    chk("h_rst_out", out, 0);
    chk("h_rst_error", error, 0);
    chk("h_rst_pc", dut.pc, 0);
    chk("h_rst_sp", dut.sp, 0);
    chk("h_rst_stack0", dut.stack[0], 0);
    @(negedge clk);
    rst = 1'b0;
    run_start();
    wait_done(50);
    chk("h_rerun_halted", halted, 1);
    chk("h_rerun_out", out, 8);
    prog(0, PUSHM, 8'h10); prog(1, POP, 8'hFF); prog(2, HLT, 8'd0);
    run_start();
    wait_done(50);
    chk("h_mem_kept", out, 8'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/stack_machine_p.md
STACK_MACHINE_P -- requirements
Module: stack_machine_p

Interface
REQ-001 SHALL provide parameter DW, default 8: data, stack-entry and operand width.
REQ-002 SHALL provide parameter SDEPTH, default 8: stack depth in entries, a power of two of at least 2.
REQ-003 SHALL provide parameter PAW, default 5: program address width, giving 2^PAW instruction words.
REQ-004 SHALL provide parameter DAW, default 8 (DAW <= DW): data memory address width, giving 2^DAW words.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-007 SHALL have port in, input, DW bits: external data, memory-mapped at address 2^DAW-2.
REQ-008 SHALL have port start, input, 1 bit: run request, sampled only in IDLE, HALT or FAULT.
REQ-009 SHALL have ports prog_we (1), prog_addr (PAW) and prog_wdata (4+DW), inputs: program write port.
REQ-010 SHALL have port out, output, DW bits: the memory word at address 2^DAW-1.
REQ-011 SHALL have port error, output, 1 bit: bit 0 of the memory word at address 2^DAW-3.
REQ-012 SHALL have ports busy (1), halted (1) and fault_code (2), outputs: machine state.

Function
REQ-013 SHALL implement FSM states IDLE, RUN, HALT and FAULT, with busy=1 only in RUN and halted=1 only in HALT.
REQ-014 SHALL, when start=1 in IDLE, HALT or FAULT, enter RUN next cycle with pc=0, sp=0, flags=0 and fault_code=0; the first instruction executes in the first RUN cycle.
REQ-015 SHALL write prog_wdata to program word prog_addr when prog_we=1 outside RUN, and SHALL ignore prog_we in RUN.
REQ-016 SHALL decode instruction bits [DW+3:DW] as the opcode and [DW-1:0] as the operand; data addresses use operand[DAW-1:0].
REQ-017 SHALL execute one instruction per RUN cycle, with pc incrementing modulo 2^PAW unless the instruction jumps.
REQ-018 SHALL implement opcodes 0 PUSHC (push operand), 1 PUSHM (push mem[addr]), 2 POP (mem[addr] = top, pop) and 3 J (pc = top[PAW-1:0], pop).
REQ-019 SHALL implement opcodes 4 JZ and 5 JS: always pop the top entry; load pc from it only if the z or s flag is set, otherwise pc+1.
REQ-020 SHALL implement opcodes 6 ADD (next + top) and 7 SUB (next - top): replace the two entries with the DW-bit truncated result, sp-1.
REQ-021 SHALL implement opcode 8 HALT: enter HALT with pc, sp and the stack frozen.
REQ-022 SHALL update flags only on arithmetic: z = (result == 0), s = result[DW-1].
REQ-023 SHALL, on a push with sp == SDEPTH, enter FAULT with fault_code=1 (overflow).
REQ-024 SHALL, on an instruction needing more entries than sp holds, enter FAULT with fault_code=2 (underflow).
REQ-025 SHALL treat an unimplemented opcode as illegal and enter FAULT with fault_code=3.
REQ-026 SHALL leave every faulting instruction without effect: pc, sp, stack, flags and memory unchanged.
REQ-027 SHALL capture in into mem[2^DAW-2] every cycle in all states; POP to this address is discarded.
REQ-028 SHALL write mem[2^DAW-3] = {0, out[DW-1] | in[DW-1]} every cycle; POP to this address is discarded.
REQ-029 SHALL, on POP to address 2^DAW-1, present the value on out on the following cycle.

Reset
REQ-030 SHALL, on rst, asynchronously force IDLE with pc=0, sp=0, flags=0, all stack entries 0, out=0, error=0, fault_code=0, busy=0 and halted=0.
REQ-031 SHALL preserve program memory and unmapped data memory across reset, including reset asserted mid-RUN.

Configuration
REQ-032 SHALL, with STACK_MACHINE_MUL_EN defined, implement opcode 9 MUL: the low DW bits of next*top replace both entries, flags update and sp-1.
REQ-033 SHALL, without STACK_MACHINE_MUL_EN, treat opcode 9 as illegal (fault_code=3) and build no multiplier.

Verification
REQ-034 Bench SHALL run PUSHC 5, PUSHC 3, ADD, POP 255, HALT then start -> out=8, halted=1, z=0 after 5 RUN cycles.
REQ-035 Bench SHALL run PUSHC 3, PUSHC 5, SUB, PUSHC 7, JS -> result 0xFE, s=1, pc=7, sp=1.
REQ-036 Bench SHALL run 9 PUSHC with SDEPTH=8 -> fault_code=1 on the 9th, sp stays 8, top holds the 8th value.
REQ-037 Bench SHALL run PUSHC 1, ADD -> fault_code=2, sp=1, stack[0]=1; then start -> RUN, fault_code=0.
REQ-038 Bench SHALL run opcode 9 on 6 and 7 -> 42 with STACK_MACHINE_MUL_EN defined, fault_code=3 without it; opcode 15 -> fault_code=3 in both builds.
REQ-039 Bench SHALL assert rst mid-RUN -> immediate IDLE, out=0; then start -> the same program reruns from pc=0 unchanged.
